demod_integrator: RTL and testbench



---
 rtl/demod_pkg.sv | 54 +++++
 rtl/demod_integrator_if.sv | 31 +++
 rtl/trig_lut.sv | 18 +
 rtl/demod_integrator.sv | 198 +++++++++++++++++++
 tb/tb_demod_integrator.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/demod_pkg.sv
// Shared constants, types and LUT builder for the I/Q down-convert and integrate block.
package demod_pkg;

   localparam int LANES      = 5;
   localparam int SAMPLE_W   = 16;
   localparam int PHASE_W    = 14;
   localparam int ACC_W      = 48;
   localparam int LUT_ADDR_W = 8;
   localparam int LUT_DEPTH  = 1 << LUT_ADDR_W;
   localparam int LEN_W      = 11;
   localparam int PROD_W     = 2 * SAMPLE_W;   // one 16x16 signed product
   localparam int CROSS_W    = PROD_W + 1;     // sum/difference of two products
   localparam int LSUM_W     = CROSS_W + 3;    // five lanes of cross terms
   localparam int LUT_AMP    = 32767;

   // Last value of the drain timer; DONE follows once the final beat has
   // landed in the accumulator and had one cycle to settle.
   localparam logic [2:0] DRAIN_LAST = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [PROD_W-1:0]   product_t;
   typedef logic signed [CROSS_W-1:0]  cross_t;
   typedef logic signed [LSUM_W-1:0]   lane_sum_t;
   typedef logic signed [ACC_W-1:0]    acc_t;

   typedef logic [LUT_DEPTH-1:0][2*SAMPLE_W-1:0] trig_rom_t;

   // Round half away from zero.
   function automatic int round_to_int(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      else          return -$rtoi(0.5 - x);
   endfunction

   // Elaboration-time table: entry a holds {cos, sin} of a/256 of a turn.
   function automatic trig_rom_t build_trig_rom();
      trig_rom_t rom;
      real       ang;
      rom = '0;
      for (int a = 0; a < LUT_DEPTH; a++) begin
         ang    = 2.0 * 3.14159265358979323846 * real'(a) / real'(LUT_DEPTH);
         rom[a] = {SAMPLE_W'(round_to_int(real'(LUT_AMP) * $cos(ang))),
                   SAMPLE_W'(round_to_int(real'(LUT_AMP) * $sin(ang)))};
      end
      return rom;
   endfunction

endpackage

// File: rtl/demod_integrator_if.sv
// Sample/phase input bundle, window control and integrated result bus.
// Handshake: a beat transfers on a rising clk100 edge where in_valid is high
// while the window is collecting; there is no ready, the block never stalls.
// start is a one-cycle request honoured only while idle; result_valid is a
// one-cycle pulse after which acc_i/acc_q stay stable until the next window.
interface demod_integrator_if;
   import demod_pkg::*;

   logic                               start;
   logic [LEN_W-1:0]                   sample_length;
   logic                               in_valid;
   logic [LANES-1:0][SAMPLE_W-1:0]     data_i_shift;
   logic [LANES-1:0][SAMPLE_W-1:0]     data_q_shift;
   logic [LANES-1:0][PHASE_W-1:0]      phase_vals;
   logic                               busy;
   logic                               result_valid;
   logic signed [ACC_W-1:0]            acc_i;
   logic signed [ACC_W-1:0]            acc_q;
   state_t                             state;

   modport master (
      output start, sample_length, in_valid, data_i_shift, data_q_shift, phase_vals,
      input  busy, result_valid, acc_i, acc_q, state
   );

   modport slave (
      input  start, sample_length, in_valid, data_i_shift, data_q_shift, phase_vals,
      output busy, result_valid, acc_i, acc_q, state
   );

endinterface

// File: rtl/trig_lut.sv
// Synchronous 256-entry cos/sin ROM, one cycle read latency.
module trig_lut
   import demod_pkg::*;
(
   input  logic                  clk,
   input  logic [LUT_ADDR_W-1:0] addr,
   output sample_t               cos_val,
   output sample_t               sin_val
);

   localparam trig_rom_t ROM = build_trig_rom();

   // Registered table read; contents are constant so no reset is needed.
   always_ff @(posedge clk) begin
      {cos_val, sin_val} <= ROM[addr];
   end

endmodule

// File: rtl/demod_integrator.sv
// Five-lane digital down-conversion followed by windowed I/Q integration.
module demod_integrator
   import demod_pkg::*;
(
   input  logic              clk100,
   input  logic              reset_n,
   demod_integrator_if.slave bus
);

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] beat_cnt;
   logic [2:0]       drain_cnt;
   logic             start_ok;
   logic             accept;
   logic             last_beat;

   assign start_ok  = (state == IDLE) && bus.start && (bus.sample_length != '0);
   assign accept    = (state == RUN) && bus.in_valid;
   assign last_beat = accept && ((beat_cnt + 1'b1) == len_r);

   // FSM state register
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok)                state_nxt = RUN;
         RUN:     if (last_beat)               state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
         DONE:                                 state_nxt = IDLE;
         default:                              state_nxt = IDLE;
      endcase
   end

   // Window length latch, accepted-beat counter and drain timer
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         len_r     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (start_ok) begin
            len_r    <= bus.sample_length;
            beat_cnt <= '0;
         end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
         else                drain_cnt <= '0;
      end
   end

   sample_t lut_cos [LANES];
   sample_t lut_sin [LANES];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      trig_lut u_lut (
         .clk     (clk100),
         .addr    (bus.phase_vals[k][PHASE_W-1 -: LUT_ADDR_W]),
         .cos_val (lut_cos[k]),
         .sin_val (lut_sin[k])
      );
   end

   sample_t   s0_i [LANES];
   sample_t   s0_q [LANES];
   logic      s0_v;
   sample_t   s1_i [LANES];
   sample_t   s1_q [LANES];
   sample_t   s1_cos [LANES];
   sample_t   s1_sin [LANES];
   logic      s1_v;
   product_t  p_ic [LANES];
   product_t  p_qs [LANES];
   product_t  p_qc [LANES];
   product_t  p_is [LANES];
   logic      s2_v;
   cross_t    cross_i [LANES];
   cross_t    cross_q [LANES];
   lane_sum_t sum_i_c;
   lane_sum_t sum_q_c;
   lane_sum_t s3_i;
   lane_sum_t s3_q;
   logic      s3_v;
   acc_t      acc_i_r;
   acc_t      acc_q_r;

   // Capture samples alongside the LUT read so both reach S1 together
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         s0_v <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            s0_i[k] <= '0;
            s0_q[k] <= '0;
         end
      end else begin
         s0_v <= accept;
         for (int k = 0; k < LANES; k++) begin
            s0_i[k] <= sample_t'(bus.data_i_shift[k]);
            s0_q[k] <= sample_t'(bus.data_q_shift[k]);
         end
      end
   end

   // S1: register LUT outputs with their aligned samples
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         s1_v <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            s1_i[k]   <= '0;
            s1_q[k]   <= '0;
            s1_cos[k] <= '0;
            s1_sin[k] <= '0;
         end
      end else begin
         s1_v <= s0_v;
         for (int k = 0; k < LANES; k++) begin
            s1_i[k]   <= s0_i[k];
            s1_q[k]   <= s0_q[k];
            s1_cos[k] <= lut_cos[k];
            s1_sin[k] <= lut_sin[k];
         end
      end
   end

   // S2: four signed products per lane
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         s2_v <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            p_ic[k] <= '0;
            p_qs[k] <= '0;
            p_qc[k] <= '0;
            p_is[k] <= '0;
         end
      end else begin
         s2_v <= s1_v;
         for (int k = 0; k < LANES; k++) begin
            p_ic[k] <= product_t'(s1_i[k]) * product_t'(s1_cos[k]);
            p_qs[k] <= product_t'(s1_q[k]) * product_t'(s1_sin[k]);
            p_qc[k] <= product_t'(s1_q[k]) * product_t'(s1_cos[k]);
            p_is[k] <= product_t'(s1_i[k]) * product_t'(s1_sin[k]);
         end
      end
   end

   // Rotate each lane and sum across lanes
   always_comb begin
      sum_i_c = '0;
      sum_q_c = '0;
      for (int k = 0; k < LANES; k++) begin
         cross_i[k] = cross_t'(p_ic[k]) + cross_t'(p_qs[k]);
         cross_q[k] = cross_t'(p_qc[k]) - cross_t'(p_is[k]);
         sum_i_c    = sum_i_c + lane_sum_t'(cross_i[k]);
         sum_q_c    = sum_q_c + lane_sum_t'(cross_q[k]);
      end
   end

   // S3: register the lane sums
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         s3_v <= 1'b0;
         s3_i <= '0;
         s3_q <= '0;
      end else begin
         s3_v <= s2_v;
         s3_i <= sum_i_c;
         s3_q <= sum_q_c;
      end
   end

   // S4: accumulate; an accepted start clears, otherwise the totals hold
   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         acc_i_r <= '0;
         acc_q_r <= '0;
      end else if (start_ok) begin
         acc_i_r <= '0;
         acc_q_r <= '0;
      end else if (s3_v) begin
         acc_i_r <= acc_i_r + acc_t'(s3_i);
         acc_q_r <= acc_q_r + acc_t'(s3_q);
      end
   end

   assign bus.busy         = (state != IDLE);
   assign bus.result_valid = (state == DONE);
   assign bus.acc_i        = acc_i_r;
   assign bus.acc_q        = acc_q_r;
   assign bus.state        = state;

endmodule

// File: tb/tb_demod_integrator.sv
// Directed and randomized windows for demod_integrator against a plain-arithmetic model.
module tb_demod_integrator;
  import demod_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  demod_integrator_if bus ();

  demod_integrator dut (
    .clk100  (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [2*ACC_W-1:0] exp_q[$];
  int cur_i [LANES];
  int cur_q [LANES];
  int cur_ph [LANES];
  longint last_ei = 0;
  longint last_eq = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    else          return -longint'($rtoi(0.5 - x));
  endfunction

  // Oscillator value for a 256-step turn index, amplitude 32767
  function automatic longint lo_cos(input int a);
    return rnd(32767.0 * $cos(2.0 * 3.14159265358979323846 * real'(a) / 256.0));
  endfunction

  function automatic longint lo_sin(input int a);
    return rnd(32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 256.0));
  endfunction

  // kind 0: I=1000,Q=0,ph=0; 1: same at 90 deg; 3: full-scale at 45 deg; else random
  task automatic set_beat(input int kind);
    for (int k = 0; k < LANES; k++) begin
      case (kind)
        0: begin cur_i[k] = 1000;   cur_q[k] = 0;      cur_ph[k] = 0;      end
        1: begin cur_i[k] = 1000;   cur_q[k] = 0;      cur_ph[k] = 'h1000; end
        3: begin cur_i[k] = -32768; cur_q[k] = -32768; cur_ph[k] = 'h0800; end
        default: begin
          cur_i[k]  = int'($urandom_range(0, 65535)) - 32768;
          cur_q[k]  = int'($urandom_range(0, 65535)) - 32768;
          cur_ph[k] = int'($urandom_range(0, 16383));
        end
      endcase
      bus.data_i_shift[k] = 16'(cur_i[k]);
      bus.data_q_shift[k] = 16'(cur_q[k]);
      bus.phase_vals[k]   = 14'(cur_ph[k]);
    end
  endtask

  task automatic model_add(inout longint ei, inout longint eq);
    longint c, s;
    for (int k = 0; k < LANES; k++) begin
      c = lo_cos(cur_ph[k] / 64);
      s = lo_sin(cur_ph[k] / 64);
      ei += longint'(cur_i[k]) * c + longint'(cur_q[k]) * s;
      eq += longint'(cur_q[k]) * c - longint'(cur_i[k]) * s;
    end
  endtask

  // One window. gap_mode 0: contiguous, 1: valid on even edges, 2: random gaps.
  task automatic run_window(input int len, input int kind, input int gap_mode,
                            input bit mid_start, input bit done_start);
    longint ei, eq;
    int e, last, got, pulses;
    bit v;
    logic [2*ACC_W-1:0] pair;
    ei = 0; eq = 0; e = 0; last = 0; got = 0; pulses = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sample_length = 11'(len);
    set_beat(2);
    bus.in_valid = 1'b1;               // same cycle as start: must not count
    @(posedge clk);
    while (got < len) begin
      @(negedge clk);
      check("busy_run", bus.busy, 1);
      if (mid_start && e == 2) begin
        bus.start = 1'b1;
        bus.sample_length = 11'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (gap_mode == 0)      v = 1'b1;
      else if (gap_mode == 1) v = ((e + 1) % 2 == 0);
      else                    v = ($urandom_range(0, 2) != 0);
      set_beat(v ? kind : 2);
      bus.in_valid = v;
      @(posedge clk);
      e++;
      if (v) begin
        got++;
        model_add(ei, eq);
        last = e;
      end
    end
    exp_q.push_back({ei[ACC_W-1:0], eq[ACC_W-1:0]});
    while (e < last + 8) begin
      @(negedge clk);
      check("result_valid", bus.result_valid, (e == last + 5) ? 1 : 0);
      check("busy_tail", bus.busy, (e <= last + 5) ? 1 : 0);
      if (bus.result_valid === 1'b1 && exp_q.size() > 0) begin
        pulses++;
        pair = exp_q.pop_front();
        check("acc_i", bus.acc_i, longint'(signed'(pair[2*ACC_W-1 -: ACC_W])));
        check("acc_q", bus.acc_q, longint'(signed'(pair[ACC_W-1:0])));
      end
      bus.start = done_start && (e == last + 5);
      bus.sample_length = 11'(len);
      set_beat(2);
      bus.in_valid = 1'b1;             // after the window: must be ignored
      @(posedge clk);
      e++;
    end
    @(negedge clk);
    check("pulse_count", pulses, 1);
    check("acc_i_hold", bus.acc_i, ei);
    check("acc_q_hold", bus.acc_q, eq);
    check("state_idle", int'(bus.state), int'(IDLE));
    exp_q.delete();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    last_ei = ei;
    last_eq = eq;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint pi, pq;
    bus.start = 1'b0;
    bus.sample_length = '0;
    bus.in_valid = 1'b0;
    set_beat(0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_acc_i", bus.acc_i, 0);
    check("rst_acc_q", bus.acc_q, 0);
    check("rst_state", int'(bus.state), int'(IDLE));
    rst_n = 1'b1;

    // Phase 0, 90 degrees, every-other-cycle valid
    run_window(10, 0, 0, 1'b0, 1'b0);
    run_window(10, 1, 0, 1'b0, 1'b0);
    run_window(10, 0, 1, 1'b0, 1'b0);

    // start mid-RUN and in the result_valid cycle are both ignored
    run_window(10, 0, 0, 1'b1, 1'b1);

    // Zero-length start is ignored and leaves totals alone
    @(negedge clk);
    bus.start = 1'b1;
    bus.sample_length = '0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("len0_busy", bus.busy, 0);
      check("len0_result_valid", bus.result_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("len0_acc_i", bus.acc_i, last_ei);
    check("len0_acc_q", bus.acc_q, last_eq);

    // Minimum window and random windows
    run_window(1, 2, 0, 1'b0, 1'b0);
    repeat (3) run_window(int'($urandom_range(1, 40)), 2, 2, 1'b0, 1'b0);

    // Reset in the middle of a window
    pi = 0; pq = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sample_length = 11'd10;
    bus.in_valid = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      set_beat(0);
      bus.in_valid = 1'b1;
      if (n <= 2) model_add(pi, pq);
      @(posedge clk);
    end
    @(negedge clk);
    check("partial_acc_i", bus.acc_i, pi);
    check("partial_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_result_valid", bus.result_valid, 0);
    check("abort_acc_i", bus.acc_i, 0);
    check("abort_acc_q", bus.acc_q, 0);
    check("abort_state", int'(bus.state), int'(IDLE));
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      set_beat(2);
      check("abort_hold_rv", bus.result_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    run_window(12, 2, 2, 1'b0, 1'b0);

    // Full-scale stress over the longest window
    run_window(2047, 3, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
